i2c_ctrl_bank: RTL and testbench

//  Parametrised control/status register bank for the I2C peripheral, behind the APB slave decode.

---
 rtl/i2c_ctrl_bank_pkg.sv | 25 ++
 rtl/i2c_sc_timer.sv | 29 ++
 rtl/i2c_ctrl_bank.sv | 118 +++++++++++
 tb/tb_i2c_ctrl_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_ctrl_bank_pkg.sv
// Shared definitions for the I2C control/status register bank:
// register map offsets, the default self-clear bit and the address decoder.
package i2c_ctrl_bank_pkg;

   localparam int unsigned CTL_BASE  = 0;  // first control word
   localparam int unsigned STAT_OFS  = 0;  // status word, relative to end of control words
   localparam int unsigned MASK_OFS  = 1;  // irq mask word, relative to end of control words
   localparam int unsigned CTL_RESET = 0;  // default self-clearing bit in control word 0
   localparam int unsigned SC_CNT_W  = 8;

   typedef enum logic [1:0] {
      SEL_CTL,
      SEL_STAT,
      SEL_MASK,
      SEL_NONE
   } reg_sel_e;

   function automatic reg_sel_e reg_decode(input int unsigned a, input int unsigned num_ctl);
      if (a < CTL_BASE + num_ctl)                  return SEL_CTL;
      if (a == CTL_BASE + num_ctl + STAT_OFS)      return SEL_STAT;
      if (a == CTL_BASE + num_ctl + MASK_OFS)      return SEL_MASK;
      return SEL_NONE;
   endfunction

endpackage

// File: rtl/i2c_sc_timer.sv
// Hold counter for self-clearing control bits: load restarts at HOLD,
// expire flags the edge at which the held bits must drop.
module i2c_sc_timer
   import i2c_ctrl_bank_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic pclk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   output logic expire,
   output logic busy
);

   logic [SC_CNT_W-1:0] cnt;

   always_ff @(posedge pclk) begin
      if (rst)                  cnt <= '0;
      else if (load)            cnt <= SC_CNT_W'(HOLD);
      else if (clear)           cnt <= '0;
      else if (cnt != '0)       cnt <= cnt - 1'b1;
   end

   assign busy   = (cnt != '0);
   // A reload or clear at the terminal count overrides the expiry.
   assign expire = (cnt == SC_CNT_W'(1)) && !load && !clear;

endmodule

// File: rtl/i2c_ctrl_bank.sv
// APB-side control/status register bank for the I2C peripheral: control words
// with byte strobes, self-clearing bits in word 0, sticky W1C status, irq mask.
module i2c_ctrl_bank
   import i2c_ctrl_bank_pkg::*;
#(
   parameter int                DATA_W  = 32,
   parameter int                NUM_CTL = 2,
   parameter int                STAT_W  = 8,
   parameter logic [DATA_W-1:0] SC_MASK = DATA_W'(1) << CTL_RESET,
   parameter int                SC_HOLD = 1,
   localparam int               ADDR_W  = $clog2(NUM_CTL + 2)
) (
   input  logic                      pclk,
   input  logic                      rst,
   input  logic                      write,
   input  logic                      read,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W/8-1:0]       be,
   output logic [DATA_W-1:0]         rdata,
   output logic                      rvalid,
   output logic [NUM_CTL*DATA_W-1:0] control,
   input  logic [STAT_W-1:0]         status_set,
   output logic                      irq
);

   localparam int BYTES = DATA_W / 8;

   reg_sel_e                         sel;
   logic [DATA_W-1:0]                be_mask;
   logic [NUM_CTL-1:0]               ctl_we;
   logic [NUM_CTL-1:0][DATA_W-1:0]   ctl_q, ctl_wr, ctl_d;
   logic [STAT_W-1:0]                stat_q, stat_d, mask_q, mask_d, w1c;
   logic                             stat_we, mask_we;
   logic [DATA_W-1:0]                sc_en, rd_word;
   logic                             sc_touch, sc_load, sc_clear, sc_expire, sc_busy;

   assign sel = reg_decode(32'(addr), NUM_CTL);

   for (genvar b = 0; b < BYTES; b++) begin : g_be
      assign be_mask[b*8 +: 8] = {8{be[b]}};
   end

   // Byte-merged next value for every control word.
   for (genvar k = 0; k < NUM_CTL; k++) begin : g_ctl
      assign ctl_we[k] = write && (sel == SEL_CTL) && (addr == ADDR_W'(CTL_BASE + k));
      for (genvar b = 0; b < BYTES; b++) begin : g_byte
         assign ctl_wr[k][b*8 +: 8] = (ctl_we[k] && be[b]) ? wdata[b*8 +: 8]
                                                            : ctl_q[k][b*8 +: 8];
      end
      if (k == 0) begin : g_sc
         assign ctl_d[k] = sc_expire ? (ctl_wr[k] & ~SC_MASK) : ctl_wr[k];
      end else begin : g_plain
         assign ctl_d[k] = ctl_wr[k];
      end
   end

   // Only a write that actually reaches an SC bit through its byte strobe
   // touches the hold timer; other writes to word 0 let it run on.
   assign sc_en    = SC_MASK & be_mask;
   assign sc_touch = ctl_we[0] && (sc_en != '0);
   assign sc_load  = sc_touch && ((wdata & sc_en) != '0);
   assign sc_clear = sc_touch && !sc_load && sc_busy;

   i2c_sc_timer #(
      .HOLD (SC_HOLD)
   ) u_sc_timer (
      .pclk   (pclk),
      .rst    (rst),
      .load   (sc_load),
      .clear  (sc_clear),
      .expire (sc_expire),
      .busy   (sc_busy)
   );

   assign stat_we = write && (sel == SEL_STAT);
   assign mask_we = write && (sel == SEL_MASK);
   assign w1c     = stat_we ? (wdata[STAT_W-1:0] & be_mask[STAT_W-1:0]) : '0;
   // Set is applied after the clear so a coincident event is never lost.
   assign stat_d  = (stat_q & ~w1c) | status_set;
   assign mask_d  = mask_we ? ((mask_q & ~be_mask[STAT_W-1:0]) |
                               (wdata[STAT_W-1:0] & be_mask[STAT_W-1:0]))
                            : mask_q;

   always_comb begin
      rd_word = '0;
      case (sel)
         SEL_CTL: begin
            for (int k = 0; k < NUM_CTL; k++)
               if (addr == ADDR_W'(CTL_BASE + k)) rd_word = ctl_q[k];
         end
         SEL_STAT: rd_word = DATA_W'(stat_q);
         SEL_MASK: rd_word = DATA_W'(mask_q);
         default:  rd_word = '0;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         ctl_q  <= '0;
         stat_q <= '0;
         mask_q <= '0;
         rdata  <= '0;
         rvalid <= 1'b0;
         irq    <= 1'b0;
      end else begin
         ctl_q  <= ctl_d;
         stat_q <= stat_d;
         mask_q <= mask_d;
         rvalid <= read;
         if (read) rdata <= rd_word;
         irq    <= |(stat_q & mask_q);
      end
   end

   assign control = ctl_q;

endmodule

// File: tb/tb_i2c_ctrl_bank.sv
// Directed bench for i2c_ctrl_bank: read scoreboard plus direct output checks.
module tb_i2c_ctrl_bank;

   logic        pclk = 1'b0;
   logic        rst, rst2, write, read;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [7:0]  status_set;
   logic [31:0] rdata, rdata5;
   logic        rvalid, rvalid5, irq, irq5;
   logic [95:0] control, control5;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   always #5 pclk = ~pclk;

   i2c_ctrl_bank #(.NUM_CTL(3), .SC_HOLD(3)) u_dut (
      .pclk(pclk), .rst(rst), .write(write), .read(read), .addr(addr),
      .wdata(wdata), .be(be), .rdata(rdata), .rvalid(rvalid),
      .control(control), .status_set(status_set), .irq(irq));

   i2c_ctrl_bank #(.NUM_CTL(3), .SC_HOLD(5)) u_dut5 (
      .pclk(pclk), .rst(rst2), .write(write), .read(read), .addr(addr),
      .wdata(wdata), .be(be), .rdata(rdata5), .rvalid(rvalid5),
      .control(control5), .status_set(status_set), .irq(irq5));

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      write = 1'b1; addr = a; wdata = d; be = b;
      tick();
      write = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [31:0] e);
      read = 1'b1; addr = a;
      exp_q.push_back(e);
      tick();
      read = 1'b0;
      chk("rvalid", 96'(rvalid), 96'(1));
   endtask

   task automatic do_rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
      read = 1'b1; write = 1'b1; addr = a; wdata = d; be = 4'hF;
      exp_q.push_back(e);
      tick();
      read = 1'b0; write = 1'b0;
   endtask

   // Scoreboard: every rvalid pulse must match the oldest expected read.
   always @(negedge pclk) begin
      if (!rst && rvalid) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 96'(1), 96'(0));
         else chk("rdata", 96'(rdata), 96'(exp_q.pop_front()));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst2 = 1'b1; write = 1'b0; read = 1'b0;
      addr = '0; wdata = '0; be = '0; status_set = '0;
      repeat (3) tick();
      chk("rst_control", control, '0);
      chk("rst_irq", 96'(irq), '0);
      chk("rst_rvalid", 96'(rvalid), '0);
      chk("rst_rdata", 96'(rdata), '0);
      rst = 1'b0; rst2 = 1'b0;
      tick();

      // 1: every address, including out-of-range ones, reads 0
      for (int a = 0; a < 8; a++) do_read(3'(a), 32'h0);
      tick();
      chk("rvalid_drop", 96'(rvalid), '0);
      chk("idle_irq", 96'(irq), '0);

      // 2: byte strobes
      do_write(3'd1, 32'hA5A5_1234, 4'b0011);
      chk("word1_out", 96'(control[63:32]), 96'(32'h0000_1234));
      do_read(3'd1, 32'h0000_1234);

      // 3a: SC_HOLD=3 pulse, non-SC bits survive the clear
      do_write(3'd0, 32'h0000_0F01, 4'hF);
      chk("sc_a_n0", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_a_n1", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_a_n2", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_a_n3", 96'(control[31:0]), 96'(32'h0F00));

      // 3b: rewrite at N+2 restarts the hold, clear at N+5
      do_write(3'd0, 32'h1, 4'b0001);
      tick();
      do_write(3'd0, 32'h1, 4'b0001);
      chk("sc_b_n2", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_b_n3", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_b_n4", 96'(control[31:0]), 96'(32'h0F01));
      tick(); chk("sc_b_n5", 96'(control[31:0]), 96'(32'h0F00));

      // 3c: write without SC byte enabled leaves the countdown running
      do_write(3'd0, 32'h0000_0F01, 4'hF);
      tick();
      do_write(3'd0, 32'h0000_AA00, 4'b0010);
      chk("sc_c_n2", 96'(control[31:0]), 96'(32'hAA01));
      tick(); chk("sc_c_n3", 96'(control[31:0]), 96'(32'hAA00));

      // 3d: writing the SC bit as 0 during a hold clears it at once
      do_write(3'd0, 32'h1, 4'b0001);
      do_write(3'd0, 32'h0, 4'b0001);
      chk("sc_d_clr", 96'(control[31:0]), 96'(32'hAA00));

      // 4: sticky status, mask, irq latency, W1C
      do_write(3'd4, 32'h4, 4'hF);
      status_set = 8'h05;
      tick();
      status_set = 8'h00;
      chk("irq_lag", 96'(irq), '0);
      tick(); chk("irq_set", 96'(irq), 96'(1));
      do_read(3'd3, 32'h05);
      do_write(3'd3, 32'h4, 4'hF);
      chk("irq_hold", 96'(irq), 96'(1));
      tick(); chk("irq_drop", 96'(irq), '0);
      do_read(3'd3, 32'h01);

      // 5: set beats a coincident W1C of the same bit
      status_set = 8'h04;
      do_write(3'd3, 32'h4, 4'hF);
      status_set = 8'h00;
      tick(); chk("irq_reset_win", 96'(irq), 96'(1));
      do_read(3'd3, 32'h05);

      // read/write same address returns the pre-write value
      do_rw(3'd2, 32'hDEAD_BEEF, 32'h0);
      do_read(3'd2, 32'hDEAD_BEEF);
      do_write(3'd2, 32'h1122_3344, 4'b1000);
      do_read(3'd2, 32'h11AD_BEEF);

      // mask bits above STAT_W read as 0; out-of-range write ignored
      do_write(3'd4, 32'hFFFF_FFFF, 4'hF);
      do_read(3'd4, 32'h0000_00FF);
      do_write(3'd6, 32'hFFFF_FFFF, 4'hF);
      do_read(3'd6, 32'h0);
      chk("oor_control", control, {32'h11AD_BEEF, 32'h0000_1234, 32'h0000_AA00});

      // 6: reset mid-hold on the SC_HOLD=5 instance
      do_write(3'd0, 32'h1, 4'b0001);
      chk("h5_set", 96'(control5[0]), 96'(1));
      tick();
      rst2 = 1'b1;
      tick();
      chk("h5_rst_control", control5, '0);
      chk("h5_rst_irq", 96'(irq5), '0);
      chk("h5_rst_rvalid", 96'(rvalid5), '0);
      chk("h5_rst_rdata", 96'(rdata5), '0);
      rst2 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("h5_no_pulse", 96'(control5[0]), '0);
      end

      repeat (2) tick();
      chk("sb_drained", 96'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
